// File: rtl/avalon_s_pipe_decoder.sv
// Avalon-MM address decoder: one pipelined host port fanned out to ND
// devices, with an internal error target for unmapped addresses.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   host_avn_*                host-side Avalon-MM slave port
//   devices_avn_*             flattened per-device master ports (dev i at
//                             slice [i*W +: W])
//   devices_address_low/high  inclusive address window per device
module avalon_s_pipe_decoder #(
  parameter int ND = 2,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MAX_OUT = 4,
  parameter logic [DW-1:0] ERR_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_avn_read,
  input  logic              host_avn_write,
  input  logic [AW-1:0]     host_avn_address,
  input  logic [DW/8-1:0]   host_avn_byte_enable,
  input  logic [DW-1:0]     host_avn_writedata,
  output logic [DW-1:0]     host_avn_readdata,
  output logic              host_avn_readdatavalid,
  output logic [1:0]        host_avn_response,
  output logic              host_avn_waitrequest,
  output logic [ND-1:0]     devices_avn_read,
  output logic [ND-1:0]     devices_avn_write,
  output logic [ND*AW-1:0]  devices_avn_address,
  output logic [ND*DW/8-1:0] devices_avn_byte_enable,
  output logic [ND*DW-1:0]  devices_avn_writedata,
  input  logic [ND*DW-1:0]  devices_avn_readdata,
  input  logic [ND-1:0]     devices_avn_readdatavalid,
  input  logic [ND-1:0]     devices_avn_waitrequest,
  input  logic [ND*AW-1:0]  devices_address_low,
  input  logic [ND*AW-1:0]  devices_address_high
);

  localparam int TW = $clog2(ND + 1);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [TW-1:0] ERR_TGT = TW'(ND);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic [TW-1:0] tgt;
  logic [TW-1:0] cur_tgt;
  logic [CW-1:0] cnt;
  logic          err_pend;
  logic          miss;
  logic          stall;
  logic          rd_acc;
  logic          sel_wait;
  logic          sel_rdv;
  logic [DW-1:0] sel_rdata;

  // Walk from the top index down so the lowest hit overrides.
  always_comb begin
    tgt = ERR_TGT;
    for (int i = ND - 1; i >= 0; i--) begin
      if (host_avn_address >= devices_address_low[i*AW +: AW] &&
          host_avn_address <= devices_address_high[i*AW +: AW])
        tgt = TW'(i);
    end
  end

  assign miss = (tgt == ERR_TGT);

  // sel_wait follows the decoded target; sel_rdv/rdata follow the
  // target that owns the outstanding reads.
  always_comb begin
    sel_wait  = 1'b0;
    sel_rdv   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < ND; i++) begin
      if (tgt == TW'(i))
        sel_wait = devices_avn_waitrequest[i];
      if (cur_tgt == TW'(i)) begin
        sel_rdv   = devices_avn_readdatavalid[i];
        sel_rdata = devices_avn_readdata[i*DW +: DW];
      end
    end
  end

  // A read may only follow reads to the same target, so responses
  // cannot come back out of order.
  assign stall = host_avn_read &
                 ((cnt == CNT_MAX) |
                  ((cnt != '0) & (tgt != cur_tgt)));

  assign host_avn_waitrequest = stall | sel_wait;
  assign rd_acc = host_avn_read & ~host_avn_waitrequest;

  assign devices_avn_address     = {ND{host_avn_address}};
  assign devices_avn_byte_enable = {ND{host_avn_byte_enable}};
  assign devices_avn_writedata   = {ND{host_avn_writedata}};

  always_comb begin
    devices_avn_read  = '0;
    devices_avn_write = '0;
    for (int i = 0; i < ND; i++) begin
      devices_avn_read[i]  = host_avn_read & ~stall &
                             (tgt == TW'(i));
      devices_avn_write[i] = host_avn_write &
                             (tgt == TW'(i));
    end
  end

  always_comb begin
    host_avn_readdatavalid = 1'b0;
    host_avn_readdata      = '0;
    host_avn_response      = 2'b00;
    unique case (1'b1)
      err_pend: begin
        host_avn_readdatavalid = 1'b1;
        host_avn_readdata      = ERR_DATA;
        host_avn_response      = 2'b11;
      end
      ((cnt != '0) & (cur_tgt != ERR_TGT) & sel_rdv): begin
        host_avn_readdatavalid = 1'b1;
        host_avn_readdata      = sel_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cur_tgt  <= '0;
      err_pend <= 1'b0;
    end else begin
      err_pend <= rd_acc & miss;
      if (rd_acc)
        cur_tgt <= tgt;
      if (rd_acc && !host_avn_readdatavalid &&
          cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      else if (!rd_acc && host_avn_readdatavalid &&
               cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_avalon_s_pipe_decoder.sv
// Directed bench for avalon_s_pipe_decoder with a response scoreboard.
// Two devices: dev0 0x0000-0x0FFF, dev1 0x1000-0x1FFF.
module tb_avalon_s_pipe_decoder;

  localparam int ND = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_avn_read;
  logic          host_avn_write;
  logic [31:0]   host_avn_address;
  logic [3:0]    host_avn_byte_enable;
  logic [31:0]   host_avn_writedata;
  logic [31:0]   host_avn_readdata;
  logic          host_avn_readdatavalid;
  logic [1:0]    host_avn_response;
  logic          host_avn_waitrequest;
  logic [1:0]    devices_avn_read;
  logic [1:0]    devices_avn_write;
  logic [63:0]   devices_avn_address;
  logic [7:0]    devices_avn_byte_enable;
  logic [63:0]   devices_avn_writedata;
  logic [63:0]   devices_avn_readdata;
  logic [1:0]    devices_avn_readdatavalid;
  logic [1:0]    devices_avn_waitrequest;
  logic [63:0]   devices_address_low;
  logic [63:0]   devices_address_high;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  logic [31:0] dec_a [6] = '{32'h0, 32'hFFF, 32'h1000,
                             32'h1FFF, 32'h2000, 32'h8000};
  logic [1:0]  dec_s [6] = '{2'b01, 2'b01, 2'b10,
                             2'b10, 2'b00, 2'b00};

  always #5 clk = ~clk;

  avalon_s_pipe_decoder #(
    .ND(ND), .DW(DW), .AW(AW), .MAX_OUT(MO),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_avn_read(host_avn_read),
    .host_avn_write(host_avn_write),
    .host_avn_address(host_avn_address),
    .host_avn_byte_enable(host_avn_byte_enable),
    .host_avn_writedata(host_avn_writedata),
    .host_avn_readdata(host_avn_readdata),
    .host_avn_readdatavalid(host_avn_readdatavalid),
    .host_avn_response(host_avn_response),
    .host_avn_waitrequest(host_avn_waitrequest),
    .devices_avn_read(devices_avn_read),
    .devices_avn_write(devices_avn_write),
    .devices_avn_address(devices_avn_address),
    .devices_avn_byte_enable(devices_avn_byte_enable),
    .devices_avn_writedata(devices_avn_writedata),
    .devices_avn_readdata(devices_avn_readdata),
    .devices_avn_readdatavalid(devices_avn_readdatavalid),
    .devices_avn_waitrequest(devices_avn_waitrequest),
    .devices_address_low(devices_address_low),
    .devices_address_high(devices_address_high)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    chk({tag, ".rdv"}, 64'(host_avn_readdatavalid), 64'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.sb: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".data"}, 64'(host_avn_readdata), 64'(e.data));
      chk({tag, ".resp"}, 64'(host_avn_response), 64'(e.resp));
    end
  endtask

  task automatic no_rsp(input string tag);
    chk({tag, ".rdv"}, 64'(host_avn_readdatavalid), 64'd0);
    chk({tag, ".data"}, 64'(host_avn_readdata), 64'd0);
    chk({tag, ".resp"}, 64'(host_avn_response), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    host_avn_read    = 1'b1;
    host_avn_address = a;
  endtask

  task automatic push(input logic [1:0] r,
                      input logic [31:0] d);
    exp_t e;
    e.resp = r;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    host_avn_read = 1'b0;
    host_avn_write = 1'b0;
    host_avn_address = '0;
    host_avn_byte_enable = 4'hF;
    host_avn_writedata = '0;
    devices_avn_readdata = '0;
    devices_avn_readdatavalid = '0;
    devices_avn_waitrequest = '0;
    devices_address_low  = {32'h1000, 32'h0000};
    devices_address_high = {32'h1FFF, 32'h0FFF};
    repeat (2) @(posedge clk);
    #1;
    no_rsp("reset");
    chk("reset.cnt", 64'(dut.cnt), 64'd0);
    chk("reset.wait", 64'(host_avn_waitrequest), 64'd0);
    rst = 1'b0;
    tick();

    // decode boundaries, using writes (stateless)
    for (int k = 0; k < 6; k++) begin
      host_avn_write = 1'b1;
      host_avn_address = dec_a[k];
      host_avn_writedata = 32'h0101_0000 + k;
      host_avn_byte_enable = 4'(k + 3);
      #1;
      chk($sformatf("dec%0d.wr", k),
          64'(devices_avn_write), 64'(dec_s[k]));
      chk($sformatf("dec%0d.wait", k),
          64'(host_avn_waitrequest), 64'd0);
      chk($sformatf("dec%0d.wd", k), 64'(devices_avn_writedata),
          {32'h0101_0000 + 32'(k), 32'h0101_0000 + 32'(k)});
      chk($sformatf("dec%0d.be", k),
          64'(devices_avn_byte_enable),
          64'({4'(k + 3), 4'(k + 3)}));
      tick();
    end
    host_avn_write = 1'b0;
    host_avn_byte_enable = 4'hF;

    // single read to dev1, 2-cycle device latency
    rd(32'h1004);
    #1;
    chk("a.wait", 64'(host_avn_waitrequest), 64'd0);
    chk("a.strobe", 64'(devices_avn_read), 64'h2);
    chk("a.addr", 64'(devices_avn_address[63:32]), 64'h1004);
    push(2'b00, 32'hA5A5_A5A5);
    tick();
    host_avn_read = 1'b0;
    #1;
    chk("a.cnt1", 64'(dut.cnt), 64'd1);
    no_rsp("a.gap");
    tick();
    devices_avn_readdatavalid = 2'b10;
    devices_avn_readdata = {32'hA5A5_A5A5, 32'h0};
    #1;
    expect_rsp("a.rsp");
    tick();
    devices_avn_readdatavalid = 2'b00;
    #1;
    no_rsp("a.after");
    chk("a.cnt0", 64'(dut.cnt), 64'd0);

    // MAX_OUT limit
    for (int k = 0; k < 4; k++) begin
      rd(32'h10 + 32'(k * 4));
      #1;
      chk($sformatf("b%0d.wait", k),
          64'(host_avn_waitrequest), 64'd0);
      chk($sformatf("b%0d.strobe", k),
          64'(devices_avn_read), 64'h1);
      push(2'b00, 32'hB000_0000 + 32'(k));
      tick();
    end
    rd(32'h20);
    #1;
    chk("b.full.wait", 64'(host_avn_waitrequest), 64'd1);
    chk("b.full.strobe", 64'(devices_avn_read), 64'h0);
    chk("b.full.cnt", 64'(dut.cnt), 64'd4);
    tick();
    devices_avn_readdatavalid = 2'b01;
    devices_avn_readdata = {32'h0, 32'hB000_0000};
    #1;
    expect_rsp("b.rsp0");
    chk("b.still.wait", 64'(host_avn_waitrequest), 64'd1);
    tick();
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("b.go.wait", 64'(host_avn_waitrequest), 64'd0);
    chk("b.go.strobe", 64'(devices_avn_read), 64'h1);
    push(2'b00, 32'hB000_0004);
    tick();
    host_avn_read = 1'b0;
    for (int k = 1; k < 5; k++) begin
      devices_avn_readdatavalid = 2'b01;
      devices_avn_readdata = {32'h0, 32'hB000_0000 + 32'(k)};
      #1;
      expect_rsp($sformatf("b.rsp%0d", k));
      tick();
    end
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("b.cnt0", 64'(dut.cnt), 64'd0);

    // target switch stalls until dev0 drains
    rd(32'h30);
    #1;
    chk("c.wait0", 64'(host_avn_waitrequest), 64'd0);
    push(2'b00, 32'hC000_0001);
    tick();
    rd(32'h1030);
    devices_avn_readdatavalid = 2'b10;
    devices_avn_readdata = {32'h5555_5555, 32'h0};
    #1;
    chk("c.stall", 64'(host_avn_waitrequest), 64'd1);
    chk("c.strobe", 64'(devices_avn_read), 64'h0);
    no_rsp("c.ignore");
    tick();
    devices_avn_readdatavalid = 2'b01;
    devices_avn_readdata = {32'h0, 32'hC000_0001};
    #1;
    expect_rsp("c.rsp1");
    chk("c.stall2", 64'(host_avn_waitrequest), 64'd1);
    tick();
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("c.go", 64'(host_avn_waitrequest), 64'd0);
    chk("c.strobe2", 64'(devices_avn_read), 64'h2);
    push(2'b00, 32'hC000_0002);
    tick();
    host_avn_read = 1'b0;
    devices_avn_readdatavalid = 2'b10;
    devices_avn_readdata = {32'hC000_0002, 32'h0};
    #1;
    expect_rsp("c.rsp2");
    tick();
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("c.cnt0", 64'(dut.cnt), 64'd0);

    // unmapped read and write
    devices_avn_waitrequest = 2'b01;
    rd(32'h8000);
    #1;
    chk("d.wait", 64'(host_avn_waitrequest), 64'd0);
    chk("d.strobe", 64'(devices_avn_read), 64'h0);
    push(2'b11, ERR);
    tick();
    host_avn_read = 1'b0;
    devices_avn_waitrequest = 2'b00;
    #1;
    expect_rsp("d.err");
    tick();
    no_rsp("d.after");
    chk("d.cnt0", 64'(dut.cnt), 64'd0);
    host_avn_write = 1'b1;
    host_avn_address = 32'h8000;
    #1;
    chk("d.wr.wait", 64'(host_avn_waitrequest), 64'd0);
    chk("d.wr.strobe", 64'(devices_avn_write), 64'h0);
    tick();
    host_avn_address = 32'h1100;
    devices_avn_waitrequest = 2'b10;
    #1;
    chk("d.dwait", 64'(host_avn_waitrequest), 64'd1);
    chk("d.dwait.strobe", 64'(devices_avn_write), 64'h2);
    tick();
    host_avn_write = 1'b0;
    devices_avn_waitrequest = 2'b00;
    #1;
    no_rsp("d.wr.norsp");

    // response and new read in the same cycle
    rd(32'h40);
    #1;
    chk("e.wait0", 64'(host_avn_waitrequest), 64'd0);
    push(2'b00, 32'hE000_0001);
    tick();
    rd(32'h44);
    devices_avn_readdatavalid = 2'b01;
    devices_avn_readdata = {32'h0, 32'hE000_0001};
    #1;
    expect_rsp("e.rsp1");
    chk("e.wait1", 64'(host_avn_waitrequest), 64'd0);
    push(2'b00, 32'hE000_0002);
    tick();
    host_avn_read = 1'b0;
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("e.cnt1", 64'(dut.cnt), 64'd1);
    devices_avn_readdatavalid = 2'b01;
    devices_avn_readdata = {32'h0, 32'hE000_0002};
    #1;
    expect_rsp("e.rsp2");
    tick();
    devices_avn_readdatavalid = 2'b00;
    #1;
    chk("e.cnt0", 64'(dut.cnt), 64'd0);

    // reset with reads outstanding
    rd(32'h50);
    tick();
    rd(32'h54);
    tick();
    host_avn_read = 1'b0;
    #1;
    chk("f.cnt2", 64'(dut.cnt), 64'd2);
    host_avn_write = 1'b1;
    host_avn_address = 32'h1200;
    #1;
    chk("f.wr.wait", 64'(host_avn_waitrequest), 64'd0);
    chk("f.wr.strobe", 64'(devices_avn_write), 64'h2);
    tick();
    host_avn_write = 1'b0;
    rst = 1'b1;
    #1;
    chk("f.rst.cnt", 64'(dut.cnt), 64'd0);
    no_rsp("f.rst");
    tick();
    rst = 1'b0;
    devices_avn_readdatavalid = 2'b01;
    devices_avn_readdata = {32'h0, 32'h1234_5678};
    #1;
    no_rsp("f.late");
    chk("f.cnt0", 64'(dut.cnt), 64'd0);
    tick();
    devices_avn_readdatavalid = 2'b00;

    chk("sb.empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
